ex_wb_stage: RTL and testbench

EX_WB_STAGE -- requirements
Module: ex_wb_stage

---
 rtl/ex_wb_stage.sv | 193 +++++++++++++++++++
 tb/tb_ex_wb_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: combined execute-to-writeback stage of an RV32I pipeline.
// It retires ALU results directly and runs loads and stores on a simple
// req/ack data-memory port. A memory access stalls the upstream stage until
// the ack arrives or the timeout expires.
//
// Ports:
//   clk_i, rst_i           clock; asynchronous active-high reset
//   ex_*                   instruction presented by EX (valid, flush, rd, result, store data, mem ctl, funct3)
//   dmem_*                 data memory request/response (word-aligned address, byte enables)
//   wb_*                   writeback to the register file and the forwarding unit
//   stall_o                high while a memory access is outstanding
//   misalign_o, bus_err_o  one-cycle error pulses
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready to accept; ALU results retire on the accept edge
// MEM_WAIT | request outstanding; EX held; waiting for ack or timeout
module ex_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic        flush_i,
  input  logic        ex_reg_write_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [31:0] ex_store_data_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_mem_write_i,
  input  logic [2:0]  ex_funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_t;

  // Timeout fires on the edge that ends the TIMEOUT_CYCLES-th wait cycle.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [9:0]  cnt;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        is_mem;
  logic [1:0]  size_in;   // 0 byte, 1 half, 2 word
  logic        misaligned;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Both outputs decode directly from the state flop, so they are glitch-free.
  assign stall_o    = (state == MEM_WAIT);
  assign dmem_req_o = (state == MEM_WAIT);

  assign accept = (state == IDLE) && ex_valid_i && !flush_i;
  assign is_mem = ex_mem_read_i | ex_mem_write_i;

  always_comb begin
    size_in    = 2'd2;
    be_in      = 4'b1111;
    wdata_in   = ex_store_data_i;
    if (ex_mem_write_i) begin
      case (ex_funct3_i)
        3'b000:  size_in = 2'd0;
        3'b001:  size_in = 2'd1;
        default: size_in = 2'd2;
      endcase
    end else begin
      case (ex_funct3_i)
        3'b000, 3'b100: size_in = 2'd0;
        3'b001, 3'b101: size_in = 2'd1;
        default:        size_in = 2'd2;
      endcase
    end
    misaligned = ((size_in == 2'd1) && ex_alu_result_i[0]) ||
                 ((size_in == 2'd2) && (ex_alu_result_i[1:0] != 2'b00));
    case (size_in)
      2'd0: begin
        be_in    = 4'b0001 << ex_alu_result_i[1:0];
        wdata_in = {4{ex_store_data_i[7:0]}};
      end
      2'd1: begin
        be_in    = 4'b0011 << ex_alu_result_i[1:0];
        wdata_in = {2{ex_store_data_i[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = ex_store_data_i;
      end
    endcase
  end

  always_comb begin
    byte_sel  = dmem_rdata_i[7:0];
    case (lane_q)
      2'd0: byte_sel = dmem_rdata_i[7:0];
      2'd1: byte_sel = dmem_rdata_i[15:8];
      2'd2: byte_sel = dmem_rdata_i[23:16];
      2'd3: byte_sel = dmem_rdata_i[31:24];
      default: byte_sel = dmem_rdata_i[7:0];
    endcase
    half_sel  = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    load_data = dmem_rdata_i;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      lane_q         <= '0;
      funct3_q       <= '0;
      rd_q           <= '0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_wdata_o   <= '0;
      dmem_be_o      <= '0;
      wb_reg_write_o <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      misalign_o     <= 1'b0;
      bus_err_o      <= 1'b0;
    end else begin
      wb_reg_write_o <= 1'b0;
      misalign_o     <= 1'b0;
      bus_err_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_reg_write_o <= ex_reg_write_i && (ex_rd_i != 5'd0);
              wb_rd_o        <= ex_rd_i;
              wb_data_o      <= ex_alu_result_i;
            end else if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              state        <= MEM_WAIT;
              cnt          <= '0;
              lane_q       <= ex_alu_result_i[1:0];
              funct3_q     <= ex_funct3_i;
              rd_q         <= ex_rd_i;
              dmem_we_o    <= ex_mem_write_i;
              dmem_addr_o  <= {ex_alu_result_i[31:2], 2'b00};
              dmem_wdata_o <= wdata_in;
              dmem_be_o    <= be_in;
            end
          end
        end
        MEM_WAIT: begin
          // Ack wins over a timeout landing on the same edge.
          if (dmem_ack_i) begin
            state <= IDLE;
            if (!dmem_we_o) begin
              wb_reg_write_o <= (rd_q != 5'd0);
              wb_rd_o        <= rd_q;
              wb_data_o      <= load_data;
            end
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i, flush_i, ex_reg_write_i, ex_mem_read_i, ex_mem_write_i;
  logic [4:0]  ex_rd_i;
  logic [31:0] ex_alu_result_i, ex_store_data_i;
  logic [2:0]  ex_funct3_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        wb_reg_write_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        stall_o, misalign_o, bus_err_o;

  int checks = 0;
  int errors = 0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_data = '0;

  ex_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .flush_i(flush_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_rd_i(ex_rd_i),
    .ex_alu_result_i(ex_alu_result_i), .ex_store_data_i(ex_store_data_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_mem_write_i(ex_mem_write_i),
    .ex_funct3_i(ex_funct3_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_reg_write_o(wb_reg_write_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Access size in bytes from the RV32I funct3 meaning.
  function automatic int size_bytes(input bit store, input int f3);
    if (store) return (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    if (f3 == 0 || f3 == 4) return 1;
    if (f3 == 1 || f3 == 5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off, input int f3);
    longint v;
    v = (longint'(rdata) >> (8 * off));
    case (f3)
      0: begin v = v & 255;   if (v >= 128)   v = v - 256;   end
      4: v = v & 255;
      1: begin v = v & 65535; if (v >= 32768) v = v - 65536; end
      5: v = v & 65535;
      default: v = longint'(rdata);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int n);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // One instruction from presentation to completion. ack_at: wait cycle in which
  // ack is given (values above TO mean never). spur: ack asserted while idle.
  task automatic do_txn(input bit valid, input bit flush, input bit rw, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] sdata, input bit mr,
                        input bit mw, input logic [2:0] f3, input int ack_at,
                        input logic [31:0] rdata, input bit spur);
    bit accepted, mem, mis, done;
    int n, off;
    logic [31:0] exp_be;
    ex_valid_i = valid; flush_i = flush; ex_reg_write_i = rw; ex_rd_i = rd;
    ex_alu_result_i = res; ex_store_data_i = sdata; ex_mem_read_i = mr;
    ex_mem_write_i = mw; ex_funct3_i = f3;
    dmem_ack_i = spur; dmem_rdata_i = $urandom;
    accepted = valid && !flush;
    mem = mr || mw;
    n = size_bytes(mw, int'(f3));
    off = int'(res[1:0]);
    mis = (n == 2 && off % 2 != 0) || (n == 4 && off != 0);
    exp_be = ((32'd1 << n) - 1) << off;
    step();
    ex_valid_i = 0; flush_i = 0; dmem_ack_i = 0;
    if (!accepted) begin
      check("drop_wbwe", wb_reg_write_o, 0);
      check("drop_req", dmem_req_o, 0);
      check("drop_stall", stall_o, 0);
      check("drop_errs", {misalign_o, bus_err_o}, 0);
      check("drop_data", wb_data_o, exp_data);
    end else if (!mem) begin
      exp_rd = rd; exp_data = res;
      check("alu_wbwe", wb_reg_write_o, rw && rd != 0);
      check("alu_rd", wb_rd_o, exp_rd);
      check("alu_data", wb_data_o, exp_data);
      check("alu_stall", {stall_o, dmem_req_o}, 0);
      step();
      check("alu_pulse", wb_reg_write_o, 0);
      check("alu_hold", wb_data_o, exp_data);
    end else if (mis) begin
      check("mis_pulse", misalign_o, 1);
      check("mis_req", {dmem_req_o, stall_o}, 0);
      check("mis_wbwe", wb_reg_write_o, 0);
      step();
      check("mis_end", {misalign_o, dmem_req_o}, 0);
    end else begin
      done = 0;
      for (int k = 1; k <= TO + 1 && !done; k++) begin
        check("mem_req", {dmem_req_o, stall_o}, 2'b11);
        check("mem_addr", dmem_addr_o, res & 32'hFFFF_FFFC);
        check("mem_we", dmem_we_o, mw);
        check("mem_be", dmem_be_o, exp_be);
        if (mw) check("mem_wdata", dmem_wdata_o, ref_wdata(sdata, n));
        if (k == ack_at) begin dmem_ack_i = 1; dmem_rdata_i = rdata; end
        step();
        dmem_ack_i = 0;
        if (k == ack_at) begin
          done = 1;
          if (!mw) begin exp_rd = rd; exp_data = ref_load(rdata, off, int'(f3)); end
          check("ret_wbwe", wb_reg_write_o, !mw && rd != 0);
          check("ret_rd", wb_rd_o, exp_rd);
          check("ret_data", wb_data_o, exp_data);
          check("ret_idle", {stall_o, dmem_req_o, bus_err_o}, 0);
        end else if (k == TO) begin
          done = 1;
          check("to_buserr", bus_err_o, 1);
          check("to_idle", {stall_o, dmem_req_o}, 0);
          check("to_wbwe", wb_reg_write_o, 0);
          check("to_hold", wb_data_o, exp_data);
        end
      end
      check("mem_done", done, 1);
      step();
      check("after_pulses", {bus_err_o, wb_reg_write_o, misalign_o}, 0);
    end
  endtask

  initial begin
    rst_i = 1; ex_valid_i = 0; flush_i = 0; ex_reg_write_i = 0; ex_rd_i = 0;
    ex_alu_result_i = 0; ex_store_data_i = 0; ex_mem_read_i = 0; ex_mem_write_i = 0;
    ex_funct3_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    #2;
    check("rst_outs", {stall_o, dmem_req_o, dmem_we_o, dmem_be_o, wb_reg_write_o,
                       misalign_o, bus_err_o}, 0);
    check("rst_vals", dmem_addr_o | dmem_wdata_o | wb_data_o | 32'(wb_rd_o), 0);
    step(); step();
    rst_i = 0;
    step();

    // Directed scenarios
    do_txn(1, 0, 1, 5'd5, 32'h0000_1234, 0, 0, 0, 3'b000, 0, 0, 1);        // ADD rd=5
    do_txn(1, 0, 1, 5'd7, 32'h0000_0103, 0, 1, 0, 3'b000, 3, 32'h80FF_FFFF, 0); // LB, ack 3rd
    do_txn(1, 0, 0, 5'd0, 32'h0000_0202, 32'h0000_ABCD, 0, 1, 3'b001, 1, 0, 0); // SH immediate
    do_txn(1, 0, 1, 5'd3, 32'h0000_0101, 0, 1, 0, 3'b010, 1, 0, 0);          // LW misaligned
    do_txn(1, 0, 1, 5'd4, 32'h0000_0300, 0, 1, 0, 3'b010, 99, 0, 0);         // timeout
    do_txn(1, 0, 1, 5'd4, 32'h0000_0300, 0, 1, 0, 3'b010, TO, 32'hCAFE_F00D, 0); // ack on last
    do_txn(1, 0, 1, 5'd0, 32'h0000_0400, 0, 1, 0, 3'b010, 2, 32'h1111_2222, 0);  // rd=0 load
    do_txn(1, 1, 1, 5'd9, 32'h0000_0500, 0, 1, 0, 3'b010, 1, 0, 1);          // flushed load
    do_txn(1, 0, 1, 5'd0, 32'h0000_0600, 0, 0, 0, 3'b000, 0, 0, 0);          // ALU rd=0

    // Reset in the middle of a wait
    ex_valid_i = 1; ex_mem_read_i = 1; ex_mem_write_i = 0; ex_funct3_i = 3'b010;
    ex_alu_result_i = 32'h0000_0700; ex_rd_i = 5'd11;
    step();
    ex_valid_i = 0; ex_mem_read_i = 0;
    step();
    check("pre_rst_stall", stall_o, 1);
    #2 rst_i = 1;
    #1;
    check("midrst_outs", {stall_o, dmem_req_o, dmem_we_o, dmem_be_o, wb_reg_write_o,
                          misalign_o, bus_err_o}, 0);
    check("midrst_vals", dmem_addr_o | dmem_wdata_o | wb_data_o | 32'(wb_rd_o), 0);
    exp_rd = 0; exp_data = 0;
    step();
    rst_i = 0; dmem_ack_i = 1; dmem_rdata_i = 32'hDEAD_BEEF;
    step();
    check("stray_ack", {wb_reg_write_o, dmem_req_o, stall_o}, 0);
    check("stray_data", wb_data_o, 0);
    dmem_ack_i = 0;
    step();

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
      do_txn(($urandom % 8) != 0, ($urandom % 6) == 0, $urandom % 2, 5'($urandom),
             a, $urandom, kind == 2, kind == 3, 3'($urandom),
             $urandom_range(1, TO + 1), $urandom, $urandom % 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
